mpc_operand_slicer: RTL and testbench

Operand-slicing stage directly downstream of the mixed-precision controller. It owns the mixed-precision cycle CSR (0x00D), which the controller reads as its current cycle and updates via its write strobe. For each dot-product beat, it extracts the chunk of the low-precision operand selected by that cycle, sign- or zero-extends it to the wide lane width, and hands a registered operand pair to the dot-product unit over a valid/ready handshake.

---
 rtl/mpc_operand_slicer.sv | 178 +++++++++++++++++
 tb/tb_mpc_operand_slicer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_operand_slicer.sv
// Operand slicer behind the mixed-precision controller: owns the cycle CSR (0x00D) and expands narrow chunks to wide lanes.
// Optional one-entry skid buffer on the input handshake when MPC_SLICER_SKID_EN is defined.

package mpc_slicer_pkg;

  localparam int unsigned NBITS_MIXED_CYCLES = 4;

  typedef enum logic [3:0] {
    IVEC_FMT_32,
    IVEC_FMT_16,
    IVEC_FMT_8,
    IVEC_FMT_4,
    IVEC_FMT_2,
    IVEC_MIXED_2X4,
    IVEC_MIXED_4X8,
    IVEC_MIXED_8X16,
    IVEC_MIXED_2X8,
    IVEC_MIXED_4X16,
    IVEC_MIXED_2X16
  } ivec_mode_fmt;

  // Element geometry as log2 of narrow width n and wide width w.
  typedef struct packed {
    logic       mixed;
    logic [2:0] n_log;
    logic [2:0] w_log;
  } fmt_geom_t;

  function automatic fmt_geom_t fmt_geom(input ivec_mode_fmt fmt);
    fmt_geom_t g;
    case (fmt)
      IVEC_MIXED_2X4:  g = '{mixed: 1'b1, n_log: 3'd1, w_log: 3'd2};
      IVEC_MIXED_4X8:  g = '{mixed: 1'b1, n_log: 3'd2, w_log: 3'd3};
      IVEC_MIXED_8X16: g = '{mixed: 1'b1, n_log: 3'd3, w_log: 3'd4};
      IVEC_MIXED_2X8:  g = '{mixed: 1'b1, n_log: 3'd1, w_log: 3'd3};
      IVEC_MIXED_4X16: g = '{mixed: 1'b1, n_log: 3'd2, w_log: 3'd4};
      IVEC_MIXED_2X16: g = '{mixed: 1'b1, n_log: 3'd1, w_log: 3'd4};
      default:         g = '{mixed: 1'b0, n_log: 3'd0, w_log: 3'd0};
    endcase
    return g;
  endfunction

endpackage

module mpc_operand_slicer #(
  parameter int unsigned NBITS_MIXED_CYCLES = mpc_slicer_pkg::NBITS_MIXED_CYCLES,
  parameter int unsigned RESET_CYCLE        = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            csr_we_i,
  input  logic [NBITS_MIXED_CYCLES-1:0]   csr_wdata_i,
  input  logic                            wcsr_i,
  input  logic [NBITS_MIXED_CYCLES-1:0]   next_cycle_i,
  output logic [NBITS_MIXED_CYCLES-1:0]   cycle_csr_o,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  mpc_slicer_pkg::ivec_mode_fmt    ivec_fmt_i,
  input  logic                            signed_i,
  input  logic [31:0]                     op_a_i,
  input  logic [31:0]                     op_b_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [31:0]                     op_a_o,
  output logic [31:0]                     op_b_o,
  output logic [NBITS_MIXED_CYCLES-1:0]   cycle_o
);

  typedef struct packed {
    logic [31:0]                   a;
    logic [31:0]                   b;
    logic [NBITS_MIXED_CYCLES-1:0] cyc;
  } beat_t;

  logic [NBITS_MIXED_CYCLES-1:0] cycle_q;
  beat_t                         in_beat;
  beat_t                         out_q;
  logic                          valid_q;
  logic                          accept;

  // Output bit j belongs to lane j>>w_log; bits beyond the narrow width replicate the element MSB or zero.
  function automatic logic [31:0] slice_operand(
    input logic [31:0]                   b,
    input mpc_slicer_pkg::ivec_mode_fmt  fmt,
    input logic                          sgn,
    input logic [NBITS_MIXED_CYCLES-1:0] cyc
  );
    mpc_slicer_pkg::fmt_geom_t g;
    logic [31:0] res;
    int unsigned n_log, w_log, l_log, r_log, k, lane, pos, base;
    g     = mpc_slicer_pkg::fmt_geom(fmt);
    res   = b;
    n_log = 32'(g.n_log);
    w_log = 32'(g.w_log);
    l_log = 5 - w_log;
    r_log = w_log - n_log;
    k     = 32'(cyc) & ((32'd1 << r_log) - 1);
    if (g.mixed) begin
      for (int j = 0; j < 32; j++) begin
        lane = 32'(j) >> w_log;
        pos  = 32'(j) & ((32'd1 << w_log) - 1);
        base = ((k << l_log) + lane) << n_log;
        if (pos < (32'd1 << n_log)) res[j] = b[5'(base + pos)];
        else                        res[j] = sgn & b[5'(base + (32'd1 << n_log) - 1)];
      end
    end
    return res;
  endfunction

  // NOTE: every flop uses <= so all registers update from pre-edge values; a beat thus sees cycle_q before any same-edge write.
  always_ff @(posedge clk) begin
    if (rst)           cycle_q <= NBITS_MIXED_CYCLES'(RESET_CYCLE);
    else if (csr_we_i) cycle_q <= csr_wdata_i;
    else if (wcsr_i)   cycle_q <= next_cycle_i;
  end

  assign cycle_csr_o = cycle_q;

  always_comb begin
    in_beat.a   = op_a_i;
    in_beat.b   = slice_operand(op_b_i, ivec_fmt_i, signed_i, cycle_q);
    in_beat.cyc = cycle_q;
  end

  assign accept = valid_i && ready_o;

`ifdef MPC_SLICER_SKID_EN
  beat_t skid_q;
  logic  skid_valid_q;
  logic  out_free;

  assign out_free = !valid_q || ready_i;
  assign ready_o  = !skid_valid_q;

  // Accept only happens with the skid empty, so a draining skid never collides with a new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      valid_q      <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        valid_q      <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        valid_q <= accept;
        if (accept) out_q <= in_beat;
      end
    end else if (accept) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign ready_o = !valid_q || ready_i;

  // NOTE: synchronous reset clears the data registers too, since their reset value is visible on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      out_q   <= in_beat;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign valid_o = valid_q;
  assign op_a_o  = out_q.a;
  assign op_b_o  = out_q.b;
  assign cycle_o = out_q.cyc;

endmodule

// File: tb/tb_mpc_operand_slicer.sv
// Self-checking bench for mpc_operand_slicer: directed vector table, CSR/backpressure/reset sequences, random traffic vs a queue model.
module tb_mpc_operand_slicer;
  import mpc_slicer_pkg::*;

  localparam int NB = NBITS_MIXED_CYCLES;

  logic          clk = 1'b0;
  logic          rst;
  logic          csr_we_i;
  logic [NB-1:0] csr_wdata_i;
  logic          wcsr_i;
  logic [NB-1:0] next_cycle_i;
  logic [NB-1:0] cycle_csr_o;
  logic          valid_i;
  logic          ready_o;
  ivec_mode_fmt  ivec_fmt_i;
  logic          signed_i;
  logic [31:0]   op_a_i;
  logic [31:0]   op_b_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   op_a_o;
  logic [31:0]   op_b_o;
  logic [NB-1:0] cycle_o;

  always #5 clk = ~clk;

  mpc_operand_slicer dut (
    .clk(clk), .rst(rst),
    .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
    .wcsr_i(wcsr_i), .next_cycle_i(next_cycle_i),
    .cycle_csr_o(cycle_csr_o),
    .valid_i(valid_i), .ready_o(ready_o),
    .ivec_fmt_i(ivec_fmt_i), .signed_i(signed_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .cycle_o(cycle_o)
  );

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [NB-1:0] c;
  } exp_beat_t;

  typedef struct {
    ivec_mode_fmt  fmt;
    logic          sgn;
    logic [NB-1:0] cyc;
    logic [31:0]   b;
    logic [31:0]   exp_b;
  } vec_t;

  exp_beat_t     q[$];
  logic [NB-1:0] csr_m;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Extract element, interpret it numerically, then place it into its lane.
  function automatic logic [31:0] model_expand(input ivec_mode_fmt fmt, input logic sgn,
                                               input logic [NB-1:0] cyc, input logic [31:0] b);
    int n, w, r, l, k;
    longint e, res;
    case (fmt)
      IVEC_MIXED_2X4:  begin n = 2; w = 4;  end
      IVEC_MIXED_4X8:  begin n = 4; w = 8;  end
      IVEC_MIXED_8X16: begin n = 8; w = 16; end
      IVEC_MIXED_2X8:  begin n = 2; w = 8;  end
      IVEC_MIXED_4X16: begin n = 4; w = 16; end
      IVEC_MIXED_2X16: begin n = 2; w = 16; end
      default: return b;
    endcase
    r   = w / n;
    l   = 32 / w;
    k   = int'(cyc) % r;
    res = 0;
    for (int i = 0; i < l; i++) begin
      e = (longint'(b) >> ((k * l + i) * n)) & ((64'sd1 <<< n) - 1);
      if (sgn && e >= (64'sd1 <<< (n - 1))) e = e - (64'sd1 <<< n);
      res = res | ((e & ((64'sd1 <<< w) - 1)) <<< (i * w));
    end
    return 32'(res);
  endfunction

  // One clock with model update; inputs must already be set by the caller.
  task automatic drive_cycle(output bit acc);
    bit        rdy;
    exp_beat_t e;
    #1;
`ifdef MPC_SLICER_SKID_EN
    rdy = (q.size() < 2);
`else
    rdy = (q.size() == 0) || ready_i;
`endif
    if (!rst) check("ready_o", 32'(ready_o), 32'(rdy));
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      q.delete();
      csr_m = '0;
    end else begin
      if (q.size() > 0 && ready_i) void'(q.pop_front());
      if (valid_i && rdy) begin
        e.a = op_a_i;
        e.b = model_expand(ivec_fmt_i, signed_i, csr_m, op_b_i);
        e.c = csr_m;
        q.push_back(e);
        acc = 1'b1;
      end
      if (csr_we_i)    csr_m = csr_wdata_i;
      else if (wcsr_i) csr_m = next_cycle_i;
    end
    #1;
    check("valid_o", 32'(valid_o), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("op_a_o", op_a_o, q[0].a);
      check("op_b_o", op_b_o, q[0].b);
      check("cycle_o", 32'(cycle_o), 32'(q[0].c));
    end
    check("cycle_csr_o", 32'(cycle_csr_o), 32'(csr_m));
  endtask

  initial begin
    vec_t vecs[13];
    bit   acc;
    int   stall_acc;
    int   exp_stall;

    vecs[0]  = '{IVEC_MIXED_2X4,  1'b1, 4'd1,  32'hFFFF0000, 32'hFFFFFFFF};
    vecs[1]  = '{IVEC_MIXED_2X4,  1'b1, 4'd0,  32'hFFFF0000, 32'h00000000};
    vecs[2]  = '{IVEC_MIXED_4X8,  1'b1, 4'd1,  32'h87654321, 32'hF8070605};
    vecs[3]  = '{IVEC_MIXED_4X8,  1'b0, 4'd1,  32'h87654321, 32'h08070605};
    vecs[4]  = '{IVEC_MIXED_2X16, 1'b0, 4'd7,  32'h70000000, 32'h00010003};
    vecs[5]  = '{IVEC_MIXED_2X16, 1'b1, 4'd7,  32'h70000000, 32'h0001FFFF};
    vecs[6]  = '{IVEC_MIXED_2X16, 1'b0, 4'd15, 32'h70000000, 32'h00010003};
    vecs[7]  = '{IVEC_MIXED_2X16, 1'b1, 4'd15, 32'h70000000, 32'h0001FFFF};
    vecs[8]  = '{IVEC_FMT_8,      1'b1, 4'd3,  32'h12345678, 32'h12345678};
    vecs[9]  = '{IVEC_MIXED_8X16, 1'b1, 4'd1,  32'h80FF1234, 32'hFF80FFFF};
    vecs[10] = '{IVEC_MIXED_2X8,  1'b0, 4'd2,  32'h00E40000, 32'h03020100};
    vecs[11] = '{IVEC_MIXED_2X8,  1'b1, 4'd2,  32'h00E40000, 32'hFFFE0100};
    vecs[12] = '{IVEC_MIXED_4X16, 1'b0, 4'd5,  32'h00009A00, 32'h0009000A};

    rst = 1'b1; csr_we_i = 1'b0; csr_wdata_i = '0; wcsr_i = 1'b0; next_cycle_i = '0;
    valid_i = 1'b0; ivec_fmt_i = IVEC_FMT_32; signed_i = 1'b0;
    op_a_i = '0; op_b_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset op_a_o", op_a_o, 32'd0);
    check("reset op_b_o", op_b_o, 32'd0);
    check("reset cycle_o", 32'(cycle_o), 32'd0);
    check("reset cycle_csr_o", 32'(cycle_csr_o), 32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    rst = 1'b0;
    q.delete();
    csr_m = '0;

    foreach (vecs[i]) begin
      csr_we_i = 1'b1; csr_wdata_i = vecs[i].cyc; valid_i = 1'b0;
      drive_cycle(acc);
      csr_we_i = 1'b0;
      valid_i = 1'b1; ivec_fmt_i = vecs[i].fmt; signed_i = vecs[i].sgn;
      op_b_i = vecs[i].b; op_a_i = $urandom;
      drive_cycle(acc);
      valid_i = 1'b0;
      check($sformatf("vec%0d op_b_o", i), op_b_o, vecs[i].exp_b);
      check($sformatf("vec%0d cycle_o", i), 32'(cycle_o), 32'(vecs[i].cyc));
    end
    drive_cycle(acc);

    // Software write, controller write and a beat on the same edge.
    csr_we_i = 1'b1; csr_wdata_i = 4'd2;
    drive_cycle(acc);
    csr_wdata_i = 4'd5; wcsr_i = 1'b1; next_cycle_i = 4'd3;
    valid_i = 1'b1; ivec_fmt_i = IVEC_MIXED_2X4; signed_i = 1'b0; op_b_i = 32'h0000CCCC; op_a_i = $urandom;
    drive_cycle(acc);
    check("prio beat cycle_o", 32'(cycle_o), 32'd2);
    check("prio cycle_csr_o", 32'(cycle_csr_o), 32'd5);
    csr_we_i = 1'b0; valid_i = 1'b0;
    drive_cycle(acc);
    check("wcsr cycle_csr_o", 32'(cycle_csr_o), 32'd3);
    wcsr_i = 1'b0;
    drive_cycle(acc);

    // Four stalled cycles with valid_i held: one beat held, two with the skid.
    ready_i = 1'b0; valid_i = 1'b1; stall_acc = 0;
    op_a_i = 32'hA0000000; op_b_i = $urandom;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(acc);
      if (acc) begin
        stall_acc++;
        op_a_i = op_a_i + 1; op_b_i = $urandom;
      end
    end
`ifdef MPC_SLICER_SKID_EN
    exp_stall = 2;
`else
    exp_stall = 1;
`endif
    check("stall beats stored", 32'(stall_acc), 32'(exp_stall));

    rst = 1'b1; valid_i = 1'b0;
    drive_cycle(acc);
    rst = 1'b0;
    check("rst mid-stall valid_o", 32'(valid_o), 32'd0);
    check("rst mid-stall cycle_csr_o", 32'(cycle_csr_o), 32'd0);
    check("rst mid-stall ready_o", 32'(ready_o), 32'd1);

    // Drain, then repeat the stall and release it to confirm nothing is lost or duplicated.
    ready_i = 1'b0; valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(acc);
      if (acc) op_a_i = op_a_i + 1;
    end
    ready_i = 1'b1; valid_i = 1'b0;
    repeat (3) drive_cycle(acc);
    check("drained", 32'(q.size()), 32'd0);

    for (int c = 0; c < 600; c++) begin
      valid_i      = ($urandom_range(0, 3) != 0);
      ready_i      = ($urandom_range(0, 2) != 0);
      ivec_fmt_i   = ivec_mode_fmt'($urandom_range(0, 10));
      signed_i     = 1'($urandom);
      op_a_i       = $urandom;
      op_b_i       = $urandom;
      csr_we_i     = ($urandom_range(0, 5) == 0);
      csr_wdata_i  = NB'($urandom);
      wcsr_i       = ($urandom_range(0, 2) == 0);
      next_cycle_i = NB'($urandom);
      drive_cycle(acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
